// File: rtl/pixel_fifo_writer_pkg.sv
// Shared constants and FSM encoding for the pixel fetch path and the VGA timing block.
package pixel_fifo_writer_pkg;

    // Default frame geometry and pixel width
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int DW_DEF       = 24;

    // Linear pixel address width; covers 640*480 = 307200 locations
    localparam int ADDR_W = 19;

    // Fetch FSM encoding: one memory read outstanding at most
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_fifo_writer_raster.sv
// Raster position tracker: column, row and linear address, with end-of-frame flag.
// The linear address is kept as its own incrementing counter so no row*H_ACTIVE
// multiply is needed.
module raster_counter
    import pixel_fifo_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_end
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;

    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign frame_end = col_last && row_last;

    // Step one pixel in raster order per accepted FIFO write; wrap everything at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            addr <= frame_end ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/pixel_fifo_writer.sv
// Fetches a frame of pixels from memory in raster order, one read at a time,
// and pushes each pixel into the display FIFO, honouring FIFO back-pressure.
module pixel_fifo_writer
    import pixel_fifo_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DW       = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_rvalid,
    output logic [DW-1:0]     fifo_wdata,
    output logic              wr_fifo,
    input  logic              fifo_full,
    output logic              frame_done,
    output logic              busy
);

    state_t state;
    logic   frame_end;

    // Strobes are decoded from the state register so a full FIFO blocks them in the
    // same cycle; this keeps the minimum pixel cadence at three cycles.
    assign mem_rd     = (state == REQ)   && !fifo_full;
    assign wr_fifo    = (state == WRITE) && !fifo_full;
    assign frame_done = wr_fifo && frame_end;
    assign busy       = (state != IDLE);

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .advance   (wr_fifo),
        .addr      (mem_addr),
        .frame_end (frame_end)
    );

    // Fetch sequencer: request, wait for data, write to FIFO; enable is only sampled
    // at frame boundaries so a started frame always completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fifo_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= REQ;
                end
                REQ: begin
                    if (!fifo_full) state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        fifo_wdata <= mem_rdata;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (!fifo_full) begin
                        if (frame_end && !enable) state <= IDLE;
                        else                      state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Bench for pixel_fifo_writer on a reduced 8x4 frame.
module tb_pixel_fifo_writer;
    import pixel_fifo_writer_pkg::*;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int FRAME = H * V;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [23:0]       mem_rdata;
    logic              mem_rvalid;
    logic [23:0]       fifo_wdata;
    logic              wr_fifo;
    logic              fifo_full;
    logic              frame_done;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    logic [23:0] sb[$];

    pixel_fifo_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DW       (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .fifo_wdata (fifo_wdata),
        .wr_fifo    (wr_fifo),
        .fifo_full  (fifo_full),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, en, full, rv;
        logic [23:0] rdata;
        logic        rd;
        logic [18:0] addr;
        logic        wr;
        logic [23:0] wdata;
        logic        done, busy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int a);
        return 24'(a * 40503) ^ 24'hA5C3E1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic traffic(input int target, input int full_pct, input int max_lat,
                           input int spur_pct, input int drop_at, input bit chk_gap,
                           input int exp_frames);
        int writes = 0, frames = 0, cyc = 0, last_rd = -1, lat = 0, exp_rd = 0, exp_wr = 0;
        bit pend = 1'b0;
        logic [ADDR_W-1:0] pend_addr = '0;
        sb.delete();
        enable = 1'b1; fifo_full = 1'b0; mem_rvalid = 1'b0;
        while (writes < target && cyc < 20000) begin
            @(negedge clk);
            if (fifo_full) chk("stall_quiet", 32'({mem_rd, wr_fifo}), 32'd0);
            if (mem_rd) begin
                chk("rd_addr", 32'(mem_addr), 32'(exp_rd));
                if (chk_gap && last_rd >= 0) chk("rd_gap", 32'(cyc - last_rd), 32'd3);
                last_rd   = cyc;
                pend      = 1'b1;
                pend_addr = mem_addr;
                lat       = int'($urandom_range(max_lat, 1));
                sb.push_back(pix(exp_rd));
                exp_rd = (exp_rd + 1) % FRAME;
            end
            if (wr_fifo) begin
                if (sb.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else                chk("wr_data", 32'(fifo_wdata), 32'(sb.pop_front()));
                chk("frame_done", 32'(frame_done), 32'(exp_wr == FRAME - 1));
                if (frame_done) begin
                    chk("done_addr", 32'(mem_addr), 32'(FRAME - 1));
                    frames++;
                end
                exp_wr = (exp_wr + 1) % FRAME;
                writes++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (writes >= drop_at && drop_at >= 0) enable = 1'b0;
            if (pend) begin
                lat--;
                if (lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pix(int'(pend_addr));
                    pend       = 1'b0;
                end else begin
                    mem_rvalid = 1'b0;
                end
            end else begin
                mem_rvalid = ($urandom_range(99) < 32'(spur_pct));
                mem_rdata  = 24'($urandom);
            end
            fifo_full = ($urandom_range(99) < 32'(full_pct));
        end
        chk("traffic_writes", 32'(writes), 32'(target));
        chk("frames", 32'(frames), 32'(exp_frames));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        mem_rvalid = 1'b0;
        fifo_full  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        //            rst en  full rv   rdata        rd  addr wr  wdata        done busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'hBADBAD, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h777777, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h123456, 1'b0, 19'd0, 1'b0, 24'h000000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 19'd0, 1'b1, 24'h123456, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 19'd1, 1'b0, 24'h123456, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 19'd1, 1'b0, 24'h123456, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 19'd1, 1'b0, 24'hABCDEF, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 19'd1, 1'b1, 24'hABCDEF, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 19'd2, 1'b0, 24'hABCDEF, 1'b0, 1'b1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en; fifo_full = tbl[i].full;
            mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_rd", i),     32'(mem_rd),     32'(tbl[i].rd));
            chk($sformatf("vec%0d_mem_addr", i),   32'(mem_addr),   32'(tbl[i].addr));
            chk($sformatf("vec%0d_wr_fifo", i),    32'(wr_fifo),    32'(tbl[i].wr));
            chk($sformatf("vec%0d_fifo_wdata", i), 32'(fifo_wdata), 32'(tbl[i].wdata));
            chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_busy", i),       32'(busy),       32'(tbl[i].busy));
            @(posedge clk);
            #1;
        end

        // Full frame at minimum latency, then the first read of the next frame
        do_reset();
        traffic(FRAME + 1, 0, 1, 0, -1, 1'b1, 1);

        // Two frames with random back-pressure, variable latency and spurious rvalid
        do_reset();
        traffic(2 * FRAME, 30, 4, 20, -1, 1'b0, 2);

        // FIFO full for 10 cycles in REQ, then for 10 cycles in WRITE
        do_reset();
        enable = 1'b1;
        @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall_req_rd", 32'(mem_rd), 32'd0);
            chk("stall_req_addr", 32'(mem_addr), 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("stall_req_release_rd", 32'(mem_rd), 32'd1);
        @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = 24'h3C3C3C;
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = 24'h000000; fifo_full = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall_wr_strobe", 32'({mem_rd, wr_fifo}), 32'd0);
            chk("stall_wr_data", 32'(fifo_wdata), 32'h3C3C3C);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("stall_wr_release", 32'(wr_fifo), 32'd1);
        chk("stall_wr_release_data", 32'(fifo_wdata), 32'h3C3C3C);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_next_rd", 32'(mem_rd), 32'd1);
        chk("stall_next_addr", 32'(mem_addr), 32'd1);

        // Enable dropped mid-frame: frame completes, then idle
        do_reset();
        traffic(FRAME, 20, 3, 10, 10, 1'b0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("drop_idle_busy", 32'(busy), 32'd0);
            chk("drop_idle_rd", 32'(mem_rd), 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset while waiting for read data, late rvalid afterwards
        do_reset();
        enable = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstwait_rd", 32'(mem_rd), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstwait_busy", 32'(busy), 32'd0);
        chk("rstwait_wr", 32'(wr_fifo), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 24'h55AA55;
        @(negedge clk);
        chk("rstwait_late_wr", 32'(wr_fifo), 32'd0);
        chk("rstwait_late_busy", 32'(busy), 32'd0);
        chk("rstwait_late_wdata", 32'(fifo_wdata), 32'd0);
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstwait_first_rd", 32'(mem_rd), 32'd1);
        chk("rstwait_first_addr", 32'(mem_addr), 32'd0);
        chk("rstwait_first_wr", 32'(wr_fifo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_fifo_writer.md
PIXEL_FIFO_WRITER -- requirements
Module: pixel_fifo_writer

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter DW, 24, pixel data width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  level; 1 = fetch frames continuously.
REQ-007 mem_addr  output  19  linear pixel address, row*H_ACTIVE+col.
REQ-008 mem_rd  output  1  one-cycle read strobe; mem_addr valid same cycle.
REQ-009 mem_rdata  input  DW  read data, qualified by mem_rvalid.
REQ-010 mem_rvalid  input  1  read data valid, >=1 cycle after mem_rd.
REQ-011 fifo_wdata  output  DW  pixel into display FIFO.
REQ-012 wr_fifo  output  1  one-cycle FIFO write strobe.
REQ-013 fifo_full  input  1  FIFO cannot accept a write.
REQ-014 frame_done  output  1  one-cycle pulse with last pixel write of frame.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, WRITE; one read outstanding max.
REQ-017 IDLE -> REQ next cycle when enable=1; else stay IDLE.
REQ-018 REQ: if fifo_full=0, assert mem_rd for exactly this cycle, go WAIT; if fifo_full=1, stay REQ, mem_rd=0.
REQ-019 WAIT: on mem_rvalid=1, register mem_rdata into fifo_wdata, go WRITE; mem_rvalid outside WAIT ignored.
REQ-020 WRITE: if fifo_full=0, assert wr_fifo this cycle, advance counters; else hold WRITE, wr_fifo=0, fifo_wdata stable.
REQ-021 After write: col increments; col=H_ACTIVE-1 wraps to 0 and row increments; row=V_ACTIVE-1 with col wrap ends frame.
REQ-022 Frame end: address, col, row return to 0; frame_done=1 same cycle as final wr_fifo; next state REQ if enable=1, else IDLE.
REQ-023 enable deasserted mid-frame: current frame completes; IDLE entered only at frame end.
REQ-024 mem_addr held via incrementing 19-bit counter (no multiplier); stable from REQ through WRITE.
REQ-025 Minimum per-pixel latency: mem_rd cycle N, mem_rvalid N+1, wr_fifo N+2, next mem_rd N+3.
REQ-026 Pixel order strictly raster, left-to-right, top-to-bottom; no pixel skipped or duplicated regardless of fifo_full stalls.

Reset
REQ-027 On rst=1: state IDLE, col=row=mem_addr=0, mem_rd=0, wr_fifo=0, frame_done=0, busy=0, fifo_wdata=0.
REQ-028 rst mid-frame abandons outstanding read; late mem_rvalid after reset ignored (state IDLE).

Structure
REQ-029 Shared package holds H_ACTIVE, V_ACTIVE, DW, address width 19, and FSM state encoding, shared with the VGA timing block.
REQ-030 One sub-module: raster_counter (col/row/address counters, wrap, frame_end flag).

Verification
REQ-031 rst, enable=1, mem_rvalid one cycle after mem_rd, fifo_full=0 -> mem_addr 0,1,2... one per 3 cycles; wr_fifo carries mem_rdata unchanged.
REQ-032 Full frame -> exactly 307200 wr_fifo pulses, frame_done once with address 307199, next mem_addr 0.
REQ-033 fifo_full=1 for 10 cycles during REQ then WRITE -> no mem_rd/wr_fifo while high; fifo_wdata stable; no pixel lost.
REQ-034 enable dropped at pixel 1000 -> writes continue to 307199, then IDLE, busy=0.
REQ-035 rst asserted in WAIT, mem_rvalid pulsed next cycle -> no wr_fifo; after release, first mem_addr=0.
REQ-036 Spurious mem_rvalid in IDLE/REQ -> no wr_fifo, state unchanged.
